seg7_bcd_fmt: RTL and testbench

Sequential binary-to-BCD formatter with autoranging for the multimeter display path. Takes a 16-bit unsigned millivolt reading from the measurement stage, converts it with a 16-step double-dabble engine, and selects a 4-digit window plus decimal-point mask. Its outputs drive the `x[15:0]` and `x_dp[3:0]` inputs of the 7-segment controller directly.

---
 rtl/seg7_bcd_fmt_if.sv | 14 +
 rtl/seg7_bcd_fmt.sv | 142 ++++++++++++++
 tb/tb_seg7_bcd_fmt.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seg7_bcd_fmt_if.sv
// Request/result bundle between the measurement stage and the BCD formatter.
// The master side drives the reading; the slave side (the formatter) returns digits.
interface seg7_bcd_fmt_if;
    logic [15:0] val;
    logic        val_vld;
    logic        busy;
    logic        done;
    logic [15:0] x;
    logic [3:0]  x_dp;
    logic        rng;

    modport master (output val, val_vld, input busy, done, x, x_dp, rng);
    modport slave  (input val, val_vld, output busy, done, x, x_dp, rng);
endinterface

// File: rtl/seg7_bcd_fmt.sv
// Sequential double-dabble mV-to-BCD formatter with X.XXX / XX.XX autoranging.
// Optional half-up rounding of the XX.XX range is compiled in with SEG7_BCD_ROUND_EN.
module seg7_bcd_fmt #(
    parameter bit DP_POL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    seg7_bcd_fmt_if.slave bus
);

`ifdef SEG7_BCD_ROUND_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, ROUND = 2'd2, LOAD = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd3} state_t;
`endif

    state_t      state_reg, state_next;
    logic [15:0] bin_reg;
    logic [19:0] bcd_reg;
    logic [3:0]  cnt_reg;
    logic [15:0] x_reg;
    logic [3:0]  x_dp_reg;
    logic        rng_reg;
    logic        done_reg;

    logic        busy, start, sh_en, ld_en;
    logic [19:0] bcd_adj;
    logic [15:0] x_sel;
    logic [3:0]  x_dp_sel;
    logic        rng_sel;

    // Add-3 correction on every nibble before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

`ifdef SEG7_BCD_ROUND_EN
    logic        rd_en;
    logic [19:0] bcd_rnd;
    logic [3:0]  carry;

    // Only the XX.XX range drops d0, so only it is rounded; carry ripples d1..d4.
    assign carry[0]       = (bcd_reg[19:16] != 4'd0) && (bcd_reg[3:0] >= 4'd5);
    assign bcd_rnd[3:0]   = bcd_reg[3:0];
    generate
        for (gi = 1; gi < 5; gi++) begin : g_rnd
            assign bcd_rnd[gi*4 +: 4] = !carry[gi-1]             ? bcd_reg[gi*4 +: 4] :
                                        (bcd_reg[gi*4 +: 4] == 4'd9) ? 4'd0 :
                                        bcd_reg[gi*4 +: 4] + 4'd1;
            if (gi < 4) begin : g_cy
                assign carry[gi] = carry[gi-1] && (bcd_reg[gi*4 +: 4] == 4'd9);
            end
        end
    endgenerate
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.val_vld) state_next = SHIFT;
`ifdef SEG7_BCD_ROUND_EN
            SHIFT: if (cnt_reg == 4'd15) state_next = ROUND;
            ROUND: state_next = LOAD;
`else
            SHIFT: if (cnt_reg == 4'd15) state_next = LOAD;
`endif
            LOAD:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_reg != IDLE);
        start = (state_reg == IDLE) && bus.val_vld;
        sh_en = (state_reg == SHIFT);
        ld_en = (state_reg == LOAD);
`ifdef SEG7_BCD_ROUND_EN
        rd_en = (state_reg == ROUND);
`endif
    end

    // Window selection on the final 5-digit result.
    always_comb begin
        if (bcd_reg[19:16] == 4'd0) begin
            x_sel    = bcd_reg[15:0];
            x_dp_sel = {DP_POL, ~DP_POL, ~DP_POL, ~DP_POL};
            rng_sel  = 1'b0;
        end else begin
            x_sel    = bcd_reg[19:4];
            x_dp_sel = {~DP_POL, DP_POL, ~DP_POL, ~DP_POL};
            rng_sel  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            x_reg    <= '0;
            x_dp_reg <= {4{~DP_POL}};
            rng_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= ld_en;
            if (start) begin
                bin_reg <= bus.val;
                bcd_reg <= '0;
                cnt_reg <= '0;
            end else if (sh_en) begin
                {bcd_reg, bin_reg} <= {bcd_adj[18:0], bin_reg, 1'b0};
                cnt_reg            <= cnt_reg + 4'd1;
            end
`ifdef SEG7_BCD_ROUND_EN
            else if (rd_en) begin
                bcd_reg <= bcd_rnd;
            end
`endif
            if (ld_en) begin
                x_reg    <= x_sel;
                x_dp_reg <= x_dp_sel;
                rng_reg  <= rng_sel;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_reg;
    assign bus.x    = x_reg;
    assign bus.x_dp = x_dp_reg;
    assign bus.rng  = rng_reg;

endmodule

// File: tb/tb_seg7_bcd_fmt.sv
// Directed-vector bench for seg7_bcd_fmt: DP_POL=1 and DP_POL=0 instances share stimulus.
// Expectations follow SEG7_BCD_ROUND_EN the same way the design does.
module tb_seg7_bcd_fmt;

`ifdef SEG7_BCD_ROUND_EN
    localparam int LAT = 18;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = 17;
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] val = '0;
    logic        val_vld = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    seg7_bcd_fmt_if bus1 ();
    seg7_bcd_fmt_if bus0 ();

    assign bus1.val     = val;
    assign bus1.val_vld = val_vld;
    assign bus0.val     = val;
    assign bus0.val_vld = val_vld;

    seg7_bcd_fmt #(.DP_POL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seg7_bcd_fmt #(.DP_POL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    typedef struct {
        logic [15:0] v;
        logic [15:0] ex;
        logic [3:0]  edp;
        logic        erng;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request; optionally re-pulse val_vld with v2 before edge E(again_at+1).
    task automatic run_conv(input logic [15:0] v, input int again_at, input logic [15:0] v2,
                            output int lat, output int busy_cyc, output int dones);
        @(negedge clk);
        val     = v;
        val_vld = 1'b1;
        @(posedge clk); #1;
        val_vld  = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        dones    = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus1.busy) busy_cyc++;
            if (i == again_at) begin
                val     = v2;
                val_vld = 1'b1;
            end
            @(posedge clk); #1;
            val_vld = 1'b0;
            if (bus1.done) begin
                dones++;
                if (lat == 0) lat = i + 1;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] ex, input logic [3:0] edp,
                                input logic erng, input int lat, input int busy_cyc, input int dones);
        chk({tag, " x"},      {16'h0, bus1.x}, {16'h0, ex});
        chk({tag, " x_dp"},   {28'h0, bus1.x_dp}, {28'h0, edp});
        chk({tag, " rng"},    {31'h0, bus1.rng}, {31'h0, erng});
        chk({tag, " lat"},    lat, LAT);
        chk({tag, " busy"},   busy_cyc, LAT);
        chk({tag, " dones"},  dones, 1);
        chk({tag, " x(p0)"},  {16'h0, bus0.x}, {16'h0, ex});
        chk({tag, " dp(p0)"}, {28'h0, bus0.x_dp}, {28'h0, ~edp});
    endtask

    initial begin
        int lat, bc, dn;

        vecs[0]  = '{16'd1234,  16'h1234, 4'b1000, 1'b0};
        vecs[1]  = '{16'd0,     16'h0000, 4'b1000, 1'b0};
        vecs[2]  = '{16'd9999,  16'h9999, 4'b1000, 1'b0};
        vecs[3]  = '{16'd10000, 16'h1000, 4'b0100, 1'b1};
        vecs[4]  = '{16'd12345, RND ? 16'h1235 : 16'h1234, 4'b0100, 1'b1};
        vecs[5]  = '{16'd65535, RND ? 16'h6554 : 16'h6553, 4'b0100, 1'b1};
        vecs[6]  = '{16'd10999, RND ? 16'h1100 : 16'h1099, 4'b0100, 1'b1};
        vecs[7]  = '{16'd2500,  16'h2500, 4'b1000, 1'b0};
        vecs[8]  = '{16'd10004, 16'h1000, 4'b0100, 1'b1};
        vecs[9]  = '{16'd10005, RND ? 16'h1001 : 16'h1000, 4'b0100, 1'b1};
        vecs[10] = '{16'd507,   16'h0507, 4'b1000, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst x",      {16'h0, bus1.x}, 32'h0);
        chk("rst x_dp",   {28'h0, bus1.x_dp}, 32'h0);
        chk("rst dp(p0)", {28'h0, bus0.x_dp}, 32'hF);
        chk("rst rng",    {31'h0, bus1.rng}, 32'h0);
        chk("rst busy",   {31'h0, bus1.busy}, 32'h0);
        chk("rst done",   {31'h0, bus1.done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            run_conv(vecs[k].v, -1, 16'h0, lat, bc, dn);
            $display("vec %0d: val=%0d x=%h x_dp=%b rng=%0d lat=%0d", k, vecs[k].v,
                     bus1.x, bus1.x_dp, bus1.rng, lat);
            check_result($sformatf("vec%0d", k), vecs[k].ex, vecs[k].edp, vecs[k].erng, lat, bc, dn);
        end

        // val_vld re-pulsed at cycle 5 of a conversion must be ignored
        run_conv(16'd3000, 4, 16'd5000, lat, bc, dn);
        $display("ignore: x=%h lat=%0d dones=%0d", bus1.x, lat, dn);
        check_result("ignore", 16'h3000, 4'b1000, 1'b0, lat, bc, dn);

        // Reset mid-conversion after a prior 4321 result
        run_conv(16'd4321, -1, 16'h0, lat, bc, dn);
        check_result("pre-rst", 16'h4321, 4'b1000, 1'b0, lat, bc, dn);
        @(negedge clk);
        val     = 16'd7777;
        val_vld = 1'b1;
        @(posedge clk); #1;
        val_vld = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        $display("midrst: x=%h x_dp=%b busy=%0d done=%0d", bus1.x, bus1.x_dp, bus1.busy, bus1.done);
        chk("midrst x",      {16'h0, bus1.x}, 32'h0);
        chk("midrst x_dp",   {28'h0, bus1.x_dp}, 32'h0);
        chk("midrst dp(p0)", {28'h0, bus0.x_dp}, 32'hF);
        chk("midrst busy",   {31'h0, bus1.busy}, 32'h0);
        chk("midrst done",   {31'h0, bus1.done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus1.done || bus1.busy) dn++;
        end
        chk("midrst quiet", dn, 0);

        run_conv(16'd1234, -1, 16'h0, lat, bc, dn);
        $display("post-rst: x=%h lat=%0d", bus1.x, lat);
        check_result("post-rst", 16'h1234, 4'b1000, 1'b0, lat, bc, dn);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
